// File: rtl/track_arb_pkg.sv
// Shared types for the track ROM arbiter: read-source tags carried alongside
// every ROM access so returned tile IDs can be routed back to their originator.
package track_arb_pkg;

    localparam int TRACK_ADDR_W = 8;
    localparam int TILE_W       = 4;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_RENDER = 2'd1,
        SRC_PHYS0  = 2'd2,
        SRC_PHYS1  = 2'd3
    } src_e;

    typedef struct packed {
        logic valid;
        src_e src;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, src: SRC_NONE};

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: the requester named by ptr wins if it is asking,
// otherwise the other one does. Purely combinational; the pointer lives upstream.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // NOTE: combinational outputs get a default before any branch so no path infers a latch.
    always_comb begin
        gnt = 2'b00;
        if (ptr == 1'b0) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end
    end

endmodule

// File: rtl/track_rom_arbiter.sv
// Shares the single-port track tile ROM between the renderer (absolute priority)
// and two physics requesters (round-robin in idle render slots), tagging every read.
module track_rom_arbiter
    import track_arb_pkg::*;
#(
    parameter int ADDR_W       = TRACK_ADDR_W,
    parameter int DATA_W       = TILE_W,
    parameter int RD_LAT       = 2,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                render_valid_in,
    input  logic [ADDR_W-1:0]   render_addr_in,
    output logic                render_valid_out,
    output logic [DATA_W-1:0]   render_data_out,
    input  logic [1:0]          phys_req_in,
    input  logic [2*ADDR_W-1:0] phys_addr_in,
    output logic [1:0]          phys_gnt_out,
    output logic [1:0]          phys_rvalid_out,
    output logic [DATA_W-1:0]   phys_rdata_out,
    output logic [1:0]          starve_out,
    output logic [ADDR_W-1:0]   rom_addr_out,
    output logic                rom_en_out,
    input  logic [DATA_W-1:0]   rom_data_in
);

    localparam int PIPE_D = 1 + RD_LAT;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic                    ptr_q, ptr_d;
    logic [ADDR_W-1:0]       rom_addr_q, rom_addr_d;
    logic                    rom_en_q, rom_en_d;
    tag_t                    iss_tag_q, iss_tag_d;
    tag_t [PIPE_D-1:0]       tag_q, tag_d;
    tag_t                    tail;
    logic                    render_valid_q, render_valid_d;
    logic [DATA_W-1:0]       render_data_q, render_data_d;
    logic [1:0]              phys_rvalid_q, phys_rvalid_d;
    logic [DATA_W-1:0]       phys_rdata_q, phys_rdata_d;
    logic [1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]              starve_q, starve_d;
    logic [1:0]              phys_req_open;
    logic [1:0]              phys_gnt;

    // A render request closes the physics arbiter for the cycle, so the pointer cannot move.
    assign phys_req_open = render_valid_in ? 2'b00 : phys_req_in;

    rr_pick2 u_pick (
        .req (phys_req_open),
        .ptr (ptr_q),
        .gnt (phys_gnt)
    );

    always_comb begin
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        rom_en_d   = 1'b0;
        iss_tag_d  = TAG_IDLE;
        if (render_valid_in) begin
            rom_addr_d = render_addr_in;
            rom_en_d   = 1'b1;
            iss_tag_d  = '{valid: 1'b1, src: SRC_RENDER};
        end else if (phys_gnt[0]) begin
            rom_addr_d = phys_addr_in[0 +: ADDR_W];
            rom_en_d   = 1'b1;
            iss_tag_d  = '{valid: 1'b1, src: SRC_PHYS0};
            ptr_d      = 1'b1;
        end else if (phys_gnt[1]) begin
            rom_addr_d = phys_addr_in[ADDR_W +: ADDR_W];
            rom_en_d   = 1'b1;
            iss_tag_d  = '{valid: 1'b1, src: SRC_PHYS1};
            ptr_d      = 1'b0;
        end
    end

    // The issue tag sits beside rom_addr_out; the pipe then covers the ROM's own
    // address register plus RD_LAT, so the tail lines up with rom_data_in.
    always_comb begin
        tag_d[0] = iss_tag_q;
        for (int k = 1; k < PIPE_D; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    assign tail = tag_q[PIPE_D-1];

    always_comb begin
        render_valid_d = 1'b0;
        render_data_d  = render_data_q;
        phys_rvalid_d  = 2'b00;
        phys_rdata_d   = phys_rdata_q;
        if (tail.valid) begin
            unique case (tail.src)
                SRC_RENDER: begin
                    render_valid_d = 1'b1;
                    render_data_d  = rom_data_in;
                end
                SRC_PHYS0: begin
                    phys_rvalid_d = 2'b01;
                    phys_rdata_d  = rom_data_in;
                end
                SRC_PHYS1: begin
                    phys_rvalid_d = 2'b10;
                    phys_rdata_d  = rom_data_in;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        starve_d = starve_q;
        for (int i = 0; i < 2; i++) begin
            if (phys_req_in[i] && !phys_gnt[i]) begin
                if (cnt_q[i] != LIMIT_C) cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else begin
                cnt_d[i] = '0;
            end
            starve_d[i] = starve_q[i] | (cnt_d[i] == LIMIT_C);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ptr_q          <= 1'b0;
            rom_addr_q     <= '0;
            rom_en_q       <= 1'b0;
            iss_tag_q      <= TAG_IDLE;
            // NOTE: the tag pipe is reset (unlike a data store) so in-flight reads are dropped.
            tag_q          <= '0;
            render_valid_q <= 1'b0;
            render_data_q  <= '0;
            phys_rvalid_q  <= 2'b00;
            phys_rdata_q   <= '0;
            cnt_q          <= '0;
            starve_q       <= 2'b00;
        end else begin
            ptr_q          <= ptr_d;
            rom_addr_q     <= rom_addr_d;
            rom_en_q       <= rom_en_d;
            iss_tag_q      <= iss_tag_d;
            tag_q          <= tag_d;
            render_valid_q <= render_valid_d;
            render_data_q  <= render_data_d;
            phys_rvalid_q  <= phys_rvalid_d;
            phys_rdata_q   <= phys_rdata_d;
            cnt_q          <= cnt_d;
            starve_q       <= starve_d;
        end
    end

    assign phys_gnt_out     = phys_gnt;
    assign rom_addr_out     = rom_addr_q;
    assign rom_en_out       = rom_en_q;
    assign render_valid_out = render_valid_q;
    assign render_data_out  = render_data_q;
    assign phys_rvalid_out  = phys_rvalid_q;
    assign phys_rdata_out   = phys_rdata_q;
    assign starve_out       = starve_q;

endmodule

// File: tb/tb_track_rom_arbiter.sv
// Self-checking bench: ROM model returning addr[3:0], a reference arbiter model
// feeding a return scoreboard, a grant vector table and hand-written corner cases.
module tb_track_rom_arbiter;
    import track_arb_pkg::*;

    localparam int AW  = 8;
    localparam int DW  = 4;
    localparam int LIM = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          rv  = 1'b0;
    logic [AW-1:0] ra  = '0;
    logic [1:0]    req = 2'b00;
    logic [2*AW-1:0] pa = '0;
    logic          render_valid_out;
    logic [DW-1:0] render_data_out;
    logic [1:0]    phys_gnt_out, phys_rvalid_out, starve_out;
    logic [DW-1:0] phys_rdata_out;
    logic [AW-1:0] rom_addr_out;
    logic          rom_en_out;
    logic [DW-1:0] rom_data = '0;

    track_rom_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .STARVE_LIMIT(LIM)
    ) dut (
        .clk_in(clk), .rst_in(rst_n),
        .render_valid_in(rv), .render_addr_in(ra),
        .render_valid_out(render_valid_out), .render_data_out(render_data_out),
        .phys_req_in(req), .phys_addr_in(pa),
        .phys_gnt_out(phys_gnt_out), .phys_rvalid_out(phys_rvalid_out),
        .phys_rdata_out(phys_rdata_out), .starve_out(starve_out),
        .rom_addr_out(rom_addr_out), .rom_en_out(rom_en_out),
        .rom_data_in(rom_data)
    );

    // ROM: internal address register, then two cycles to douta.
    logic [AW-1:0] rom_a_r = '0;
    logic [DW-1:0] rom_d1  = '0;
    always @(posedge clk) begin
        rom_a_r  <= rom_addr_out;
        rom_d1   <= rom_a_r[DW-1:0];
        rom_data <= rom_d1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_gnt(input logic rv_i, input logic [1:0] req_i, input logic p);
        if (rv_i || req_i == 2'b00) return 2'b00;
        if (req_i[p]) return p ? 2'b10 : 2'b01;
        return p ? 2'b01 : 2'b10;
    endfunction

    logic ptr_m;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_m <= 1'b0;
        else if (model_gnt(rv, req, ptr_m) == 2'b01) ptr_m <= 1'b1;
        else if (model_gnt(rv, req, ptr_m) == 2'b10) ptr_m <= 1'b0;
    end

    typedef struct {
        int         due;
        src_e       src;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    logic [DW-1:0] last_rd = '0;
    logic [DW-1:0] last_pd = '0;

    always @(posedge clk) cyc++;

    // Returns are due five counter ticks after the cycle a request is presented.
    always @(negedge clk) begin : mon
        logic [2:0] exp_v;
        logic [1:0] g;
        exp_t       e;
        if (rst_n) begin
            exp_v = 3'b000;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                case (e.src)
                    SRC_RENDER: begin exp_v[0] = 1'b1; last_rd = e.data; end
                    SRC_PHYS0:  begin exp_v[1] = 1'b1; last_pd = e.data; end
                    SRC_PHYS1:  begin exp_v[2] = 1'b1; last_pd = e.data; end
                    default: ;
                endcase
            end
            check("ret_valid", {phys_rvalid_out, render_valid_out}, exp_v);
            check("render_data", render_data_out, last_rd);
            check("phys_rdata", phys_rdata_out, last_pd);
            g = model_gnt(rv, req, ptr_m);
            check("gnt_model", phys_gnt_out, g);
            if (rv)        sb.push_back('{cyc + 5, SRC_RENDER, ra[DW-1:0]});
            else if (g[0]) sb.push_back('{cyc + 5, SRC_PHYS0, pa[DW-1:0]});
            else if (g[1]) sb.push_back('{cyc + 5, SRC_PHYS1, pa[AW +: DW]});
        end
    end

    task automatic drive(input logic rv_i, input logic [AW-1:0] ra_i, input logic [1:0] req_i,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        @(posedge clk);
        #1;
        rv  = rv_i;
        ra  = ra_i;
        req = req_i;
        pa  = {a1, a0};
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 2'b00, '0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rv    = 1'b0;
        req   = 2'b00;
        rst_n = 1'b0;
        sb.delete();
        last_rd = '0;
        last_pd = '0;
        #1;
        check("reset_outputs",
              {render_valid_out, render_data_out, phys_rvalid_out, phys_rdata_out,
               starve_out, rom_addr_out, rom_en_out}, 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic          rv;
        logic [AW-1:0] ra;
        logic [1:0]    req;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [1:0]    gnt;
    } vec_t;

    function automatic vec_t mk(input logic rv_i, input logic [AW-1:0] ra_i, input logic [1:0] req_i,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [1:0] g);
        vec_t v;
        v.rv = rv_i; v.ra = ra_i; v.req = req_i; v.a0 = a0; v.a1 = a1; v.gnt = g;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_state",
              {render_valid_out, render_data_out, phys_rvalid_out, phys_rdata_out,
               starve_out, rom_addr_out, rom_en_out, phys_gnt_out}, 32'd0);
        #2;
        rst_n = 1'b1;

        // 1: sixteen back-to-back render reads
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, AW'(i), 2'b00, '0, '0);
            check("t1_gnt", phys_gnt_out, 2'b00);
            if (i > 0) check("t1_rom_addr", {rom_en_out, rom_addr_out}, {1'b1, AW'(i - 1)});
        end
        drive(1'b0, '0, 2'b00, '0, '0);
        check("t1_rom_last", {rom_en_out, rom_addr_out}, {1'b1, 8'h0F});
        drive(1'b0, '0, 2'b00, '0, '0);
        check("t1_rom_hold", {rom_en_out, rom_addr_out}, {1'b0, 8'h0F});
        idle(5);

        // 2 and 4 plus mixes: grant table (pointer is 0 here)
        tbl.push_back(mk(1'b0, 8'h00, 2'b11, 8'h12, 8'h34, 2'b01));
        tbl.push_back(mk(1'b0, 8'h00, 2'b10, 8'h12, 8'h34, 2'b10));
        tbl.push_back(mk(1'b0, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1'b0, 8'h00, 2'b11, AW'(8'h40 + i), AW'(8'h88 + i),
                             (i % 2 == 0) ? 2'b01 : 2'b10));
        tbl.push_back(mk(1'b1, 8'h2B, 2'b11, 8'h61, 8'h72, 2'b00));
        tbl.push_back(mk(1'b0, 8'h00, 2'b11, 8'h61, 8'h72, 2'b01));
        tbl.push_back(mk(1'b0, 8'h00, 2'b01, 8'h63, 8'h72, 2'b01));
        tbl.push_back(mk(1'b1, 8'h2E, 2'b10, 8'h00, 8'h72, 2'b00));
        tbl.push_back(mk(1'b0, 8'h00, 2'b10, 8'h00, 8'h72, 2'b10));
        tbl.push_back(mk(1'b0, 8'h00, 2'b10, 8'h00, 8'h79, 2'b10));
        tbl.push_back(mk(1'b0, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00));
        foreach (tbl[i]) begin
            drive(tbl[i].rv, tbl[i].ra, tbl[i].req, tbl[i].a0, tbl[i].a1);
            check("tbl_gnt", phys_gnt_out, tbl[i].gnt);
        end
        idle(6);

        // 3: render holds off phys0 for 20 cycles
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, AW'(8'hA0 + i), 2'b01, 8'h55, 8'h00);
            check("t3_no_gnt", phys_gnt_out, 2'b00);
        end
        drive(1'b0, '0, 2'b01, 8'h55, 8'h00);
        check("t3_gnt0", phys_gnt_out, 2'b01);
        drive(1'b0, '0, 2'b00, '0, '0);
        check("t3_starve", starve_out, 2'b01);
        idle(6);
        do_reset();

        // 5: phys1 starves behind 12 render cycles
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, AW'(8'hC0 + k), 2'b10, 8'h00, 8'h77);
            check("t5_starve", starve_out, (k >= LIM) ? 2'b10 : 2'b00);
        end
        drive(1'b0, '0, 2'b10, 8'h00, 8'h77);
        check("t5_gnt1", phys_gnt_out, 2'b10);
        check("t5_starve_gnt", starve_out, 2'b10);
        drive(1'b0, '0, 2'b00, '0, '0);
        check("t5_starve_drop", starve_out, 2'b10);
        idle(6);
        check("t5_starve_hold", starve_out, 2'b10);

        // 6: reset with three mixed reads in flight, pointer left at 1
        drive(1'b1, 8'h09, 2'b00, '0, '0);
        drive(1'b0, '0, 2'b11, 8'h3C, 8'h5D);
        check("t6_gnt_a", phys_gnt_out, 2'b01);
        drive(1'b0, '0, 2'b01, 8'h4E, 8'h5D);
        check("t6_gnt_b", phys_gnt_out, 2'b01);
        do_reset();
        idle(8);
        drive(1'b0, '0, 2'b11, 8'h21, 8'h43);
        check("t6_ptr_reset", phys_gnt_out, 2'b01);
        drive(1'b0, '0, 2'b10, 8'h21, 8'h43);
        check("t6_gnt_next", phys_gnt_out, 2'b10);
        idle(7);

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/track_rom_arbiter.md
Name: track_rom_arbiter

Overview:
Shares the single-port track tile ROM (256 x 4-bit tile IDs, HIGH_PERFORMANCE, 2-cycle read) between the forward-view renderer and two physics terrain-lookup requesters (player kart, opponent kart).
- Render reads have absolute priority and are never stalled.
- Physics reads fill idle render cycles, round-robin between the two requesters.
- The block drives the ROM address port, tags every in-flight read and routes returned data back to its originator.

Parameters:
ADDR_W, 8, ROM address width (16x16 tile map)
DATA_W, 4, tile ID width
RD_LAT, 2, ROM read latency in cycles, address register to douta
STARVE_LIMIT, 1024, consecutive waiting cycles before a physics requester is flagged starved

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
render_valid_in  input  1  render read request this cycle
render_addr_in  input  ADDR_W  render tile address
render_valid_out  output  1  render data valid
render_data_out  output  DATA_W  render tile ID
phys_req_in  input  2  physics request, bit i = requester i
phys_addr_in  input  2xADDR_W  physics addresses, held stable while req high
phys_gnt_out  output  2  one-cycle grant pulse (combinational)
phys_rvalid_out  output  2  one-cycle return-data strobe per requester
phys_rdata_out  output  DATA_W  physics tile ID, shared bus
starve_out  output  2  sticky starvation flag per requester
rom_addr_out  output  ADDR_W  registered ROM address
rom_en_out  output  1  registered ROM enable
rom_data_in  input  DATA_W  ROM douta

Behaviour:
- Reset (rst_in low, async): all registered outputs 0, tag pipe cleared, RR pointer = 0, starve counters and flags 0. In-flight reads are discarded and never surface after release.
- Per-cycle issue decision, evaluated combinationally on the current inputs:
  - render_valid_in=1: issue render; phys_gnt_out=0.
  - Else if any phys_req_in: grant the requester selected by the RR pointer (pointer first, then the other). Pulse phys_gnt_out[i] that cycle. Pointer becomes 1-i.
  - Else: no issue; rom_en_out=0 next cycle.
- Issued address and enable are registered into rom_addr_out/rom_en_out at the next edge. rom_addr_out holds its last value when idle.
- Tag pipe: shift register, depth 1+RD_LAT, entries {valid, src in NONE/RENDER/PHYS0/PHYS1}, advanced every cycle.
- Output stage is registered. When the tail tag is valid, rom_data_in is captured into render_data_out or phys_rdata_out, and the matching valid/rvalid bit is set for exactly one cycle.
- Latency: a request sampled at edge t returns valid at edge t+RD_LAT+2 (4 cycles at default). This is fixed and independent of contention.
- Throughput: one read per cycle in total. Back-to-back render, back-to-back physics and interleaved mixes are all supported with no bubbles.
- Data outputs hold their last value when not valid.
- Physics handshake:
  - Requester keeps req and addr stable until gnt.
  - It may drop req before grant; this is legal and the request is forgotten.
  - It may re-request in the cycle after gnt.
  - Grant is never issued while req is low.
  - Each requester receives responses in grant order.
- Starvation:
  - Per-requester saturating counter, +1 each cycle with req=1 and gnt=0.
  - Cleared on gnt or req=0.
  - When the count reaches STARVE_LIMIT, starve_out[i] sets and stays set until reset.
  - Starvation never steals a render slot.
- Simultaneous events:
  - Render plus both physics requests: render wins and the RR pointer is unchanged.
  - Both physics requests only: pointer decides.

Decomposition:
- Package track_arb_pkg:
  - src_e enum (SRC_NONE, SRC_RENDER, SRC_PHYS0, SRC_PHYS1)
  - tag_t struct {valid, src_e}
  - constants TRACK_ADDR_W=8 and TILE_W=4
- Sub-module rr_pick2:
  - combinational 2-way round-robin picker, inputs req[1:0] and ptr, outputs gnt[1:0].
  - Pointer register and the enable that blocks it during render stay in the parent.

Test Plan:
1. Release reset; render_valid_in high 16 cycles, addr 0x00..0x0F; ROM model returns addr[3:0] -> render_valid_out high 16 consecutive cycles starting 4 cycles later, data 0..F in order; phys_gnt_out never pulses.
2. Render idle; both requesters assert together, addr0=0x12, addr1=0x34, model returns low nibble -> gnt0 at t, gnt1 at t+1; rvalid0 at t+4 with data 0x2; rvalid1 at t+5 with data 0x4.
3. Render continuous 20 cycles while phys0 holds req -> no gnt for 20 cycles; gnt0 in the first cycle render_valid_in drops; the render stream shows no gaps.
4. Render idle; both requesters hold req 10 cycles -> grants alternate 0,1,0,1,...; 10 grants total; rvalid pattern matches with 4-cycle offset.
5. STARVE_LIMIT=8; render continuous 12 cycles; phys1 req held -> starve_out[1] rises after 8 waiting cycles; still high after gnt1 and after req drops; starve_out[0]=0.
6. Three mixed reads in flight, then rst_in pulsed low 1 cycle -> all outputs 0 immediately; no render_valid_out/phys_rvalid_out after release; the next two-requester contention grants requester 0 first.
